// File: rtl/gate_bist_if.sv
// Bundle between the test controller, the sequencer and the gate under test.
// The slave side is the BIST sequencer; the master side owns start/abort/config and the gate output.
interface gate_bist_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [2:0]       gate_sel;
  logic [CNT_W-1:0] loops;
  logic             gate_y;
  logic             drv_a;
  logic             drv_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       fail_vec;
  logic             fail_valid;
  logic             aborted;

  modport master (
    output start, abort, gate_sel, loops, gate_y,
    input  drv_a, drv_b, busy, done, pass, err_count, fail_vec, fail_valid, aborted
  );

  modport slave (
    input  start, abort, gate_sel, loops, gate_y,
    output drv_a, drv_b, busy, done, pass, err_count, fail_vec, fail_valid, aborted
  );
endinterface

// File: rtl/gate_bist_sequencer.sv
// Self-test sequencer for a 2-input gate: sweeps A/B through 00..11 for a number of loops,
// compares Y with the selected truth table and reports verdict, error count and first failing vector.
module gate_bist_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input logic        clk,
  input logic        rst_n,
  gate_bist_if.slave bif
);

  localparam int               SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]    SETTLE_ZERO = {SW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Expected gate output for vector v = {a,b}
  function automatic logic gate_ref(input logic [2:0] sel, input logic [1:0] v);
    logic a;
    logic b;
    a = v[1];
    b = v[0];
    case (sel)
      3'd0:    gate_ref = a & b;
      3'd1:    gate_ref = a | b;
      3'd2:    gate_ref = ~(a & b);
      3'd3:    gate_ref = ~(a | b);
      3'd4:    gate_ref = a ^ b;
      3'd5:    gate_ref = ~(a ^ b);
      3'd6:    gate_ref = ~a;
      3'd7:    gate_ref = a;
      default: gate_ref = 1'b0;
    endcase
  endfunction

  state_t           r_state, w_state;
  logic [2:0]       r_sel, w_sel;
  logic [CNT_W-1:0] r_loops_left, w_loops_left;
  logic [1:0]       r_vec, w_vec;
  logic [SW-1:0]    r_settle, w_settle;
  logic             r_drv_a, w_drv_a;
  logic             r_drv_b, w_drv_b;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_pass, w_pass;
  logic [CNT_W-1:0] r_err, w_err;
  logic [1:0]       r_fail_vec, w_fail_vec;
  logic             r_fail_valid, w_fail_valid;
  logic             r_aborted, w_aborted;
  logic             w_mismatch;

  assign w_mismatch = (bif.gate_y != gate_ref(r_sel, r_vec));

  // State and all outputs are registered here; reset is synchronous
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sel        <= 3'd0;
      r_loops_left <= CNT_ZERO;
      r_vec        <= 2'b00;
      r_settle     <= SETTLE_ZERO;
      r_drv_a      <= 1'b0;
      r_drv_b      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= CNT_ZERO;
      r_fail_vec   <= 2'b00;
      r_fail_valid <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_sel        <= w_sel;
      r_loops_left <= w_loops_left;
      r_vec        <= w_vec;
      r_settle     <= w_settle;
      r_drv_a      <= w_drv_a;
      r_drv_b      <= w_drv_b;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_pass       <= w_pass;
      r_err        <= w_err;
      r_fail_vec   <= w_fail_vec;
      r_fail_valid <= w_fail_valid;
      r_aborted    <= w_aborted;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state      = r_state;
    w_sel        = r_sel;
    w_loops_left = r_loops_left;
    w_vec        = r_vec;
    w_settle     = r_settle;
    w_drv_a      = r_drv_a;
    w_drv_b      = r_drv_b;
    w_busy       = r_busy;
    w_done       = 1'b0;
    w_pass       = r_pass;
    w_err        = r_err;
    w_fail_vec   = r_fail_vec;
    w_fail_valid = r_fail_valid;
    w_aborted    = r_aborted;

    case (r_state)
      ST_IDLE: begin
        w_busy  = 1'b0;
        w_drv_a = 1'b0;
        w_drv_b = 1'b0;
        if (bif.start && !bif.abort) begin
          w_state      = ST_APPLY;
          w_sel        = bif.gate_sel;
          w_loops_left = (bif.loops == CNT_ZERO) ? CNT_ONE : bif.loops;
          w_vec        = 2'b00;
          w_settle     = SETTLE_ZERO;
          w_err        = CNT_ZERO;
          w_fail_vec   = 2'b00;
          w_fail_valid = 1'b0;
          w_pass       = 1'b0;
          w_aborted    = 1'b0;
          w_busy       = 1'b1;
        end else begin
          w_state = ST_IDLE;
        end
      end

      ST_APPLY: begin
        if (bif.abort) begin
          w_state   = ST_IDLE;
          w_busy    = 1'b0;
          w_drv_a   = 1'b0;
          w_drv_b   = 1'b0;
          w_aborted = 1'b1;
        end else if (r_settle != SETTLE_LAST) begin
          w_settle = r_settle + SW'(1);
        end else begin
          w_settle = SETTLE_ZERO;
          if (w_mismatch) begin
            w_err = (r_err == CNT_MAX) ? r_err : r_err + CNT_ONE;
            if (!r_fail_valid) begin
              w_fail_vec   = r_vec;
              w_fail_valid = 1'b1;
            end else begin
              w_fail_vec   = r_fail_vec;
            end
          end else begin
            w_err = r_err;
          end
          w_vec = r_vec + 2'd1;
          // Last vector of the last loop: verdict uses the count including this compare
          if ((r_vec == 2'b11) && (r_loops_left <= CNT_ONE)) begin
            w_state      = ST_FINISH;
            w_loops_left = CNT_ZERO;
            w_done       = 1'b1;
            w_busy       = 1'b0;
            w_drv_a      = 1'b0;
            w_drv_b      = 1'b0;
            w_pass       = (w_err == CNT_ZERO);
          end else begin
            if (r_vec == 2'b11) begin
              w_loops_left = r_loops_left - CNT_ONE;
            end else begin
              w_loops_left = r_loops_left;
            end
            w_drv_a = w_vec[1];
            w_drv_b = w_vec[0];
          end
        end
      end

      ST_FINISH: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
        w_drv_a = 1'b0;
        w_drv_b = 1'b0;
      end

      default: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
        w_drv_a = 1'b0;
        w_drv_b = 1'b0;
      end
    endcase
  end

  assign bif.drv_a      = r_drv_a;
  assign bif.drv_b      = r_drv_b;
  assign bif.busy       = r_busy;
  assign bif.done       = r_done;
  assign bif.pass       = r_pass;
  assign bif.err_count  = r_err;
  assign bif.fail_vec   = r_fail_vec;
  assign bif.fail_valid = r_fail_valid;
  assign bif.aborted    = r_aborted;

endmodule

// File: tb/tb_gate_bist_sequencer.sv
// Bench for gate_bist_sequencer: a gate model feeds Y, runs are predicted from truth tables
// and pushed to a scoreboard that a negedge monitor drains on every done or abort event.
module tb_gate_bist_sequencer;
  localparam int S  = 2;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gate_bist_if #(.CNT_W(CW)) bif ();

  gate_bist_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  typedef struct {
    bit is_abort;
    int cyc;
    int err;
    int fv;
    int fvec;
    int pass;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   mode = 0;
  int   fn = 0;
  logic prev_ab = 1'b0;

  // Truth table per gate_sel, bit index = {a,b}
  function automatic logic [3:0] table_of(int sel);
    case (sel)
      0: return 4'b1000;
      1: return 4'b1110;
      2: return 4'b0111;
      3: return 4'b0001;
      4: return 4'b0110;
      5: return 4'b1001;
      6: return 4'b0011;
      7: return 4'b1100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic expect_y(int sel, int v);
    logic [3:0] t;
    t = table_of(sel);
    return t[v[1:0]];
  endfunction

  // mode: 0 healthy gate of type f, 1 stuck-at-0, 2 stuck-at-1, 3 inverted gate of type f
  function automatic logic model_y(int md, int f, int v);
    case (md)
      0: return expect_y(f, v);
      1: return 1'b0;
      2: return 1'b1;
      default: return !expect_y(f, v);
    endcase
  endfunction

  assign bif.gate_y = model_y(mode, fn, int'({bif.drv_a, bif.drv_b}));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse or new abort must match the oldest predicted run
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bif.done || (bif.aborted && !prev_ab))) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: done=%0d aborted=%0d with nothing expected (cycle %0d)",
                 bif.done, bif.aborted, cyc);
      end else begin
        e = sb.pop_front();
        chk("event_is_abort", int'(!bif.done), int'(e.is_abort));
        chk("event_cycle", cyc, e.cyc);
        chk("err_count", int'(bif.err_count), e.err);
        chk("fail_valid", int'(bif.fail_valid), e.fv);
        chk("fail_vec", int'(bif.fail_vec), e.fvec);
        chk("pass", int'(bif.pass), e.pass);
        chk("busy_at_end", int'(bif.busy), 0);
        chk("drv_at_end", int'({bif.drv_a, bif.drv_b}), 0);
      end
    end
    prev_ab = bif.aborted;
  end

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, int'(bif.busy), 0);
    chk({tag, "_done"}, int'(bif.done), 0);
    chk({tag, "_drv"}, int'({bif.drv_a, bif.drv_b}), 0);
    chk({tag, "_pass"}, int'(bif.pass), 0);
    chk({tag, "_err"}, int'(bif.err_count), 0);
    chk({tag, "_fvalid"}, int'(bif.fail_valid), 0);
    chk({tag, "_fvec"}, int'(bif.fail_vec), 0);
    chk({tag, "_aborted"}, int'(bif.aborted), 0);
  endtask

  // One run, starting at a negedge. ab_t/extra_t: negedge index after start (0 = none)
  task automatic run(int sel, int lp, int md, int f, int ab_t, int extra_t);
    exp_t e;
    int   leff, total, s0, end_t;
    leff = (lp == 0) ? 1 : lp;
    mode = md;
    fn   = f;
    bif.gate_sel = sel[2:0];
    bif.loops    = lp[CW-1:0];
    bif.start    = 1'b1;
    s0    = cyc;
    total = (ab_t == 0) ? 4 * leff : (ab_t - 1) / S;
    e.err = 0; e.fv = 0; e.fvec = 0;
    for (int m = 0; m < total; m++) begin
      if (model_y(md, f, m % 4) != expect_y(sel, m % 4)) begin
        if (e.err < 255) e.err++;
        if (e.fv == 0) begin
          e.fv   = 1;
          e.fvec = m % 4;
        end
      end
    end
    e.is_abort = (ab_t != 0);
    e.cyc      = (ab_t == 0) ? s0 + 1 + 4 * leff * S : s0 + ab_t + 1;
    e.pass     = ((ab_t == 0) && (e.err == 0)) ? 1 : 0;
    sb.push_back(e);
    end_t = e.cyc - s0;
    for (int t = 1; t <= end_t + 2; t++) begin
      @(negedge clk);
      if (t <= 4 * leff * S && (ab_t == 0 || t <= ab_t)) begin
        chk("drv_seq", int'({bif.drv_a, bif.drv_b}), ((t - 1) / S) % 4);
        chk("busy_run", int'(bif.busy), 1);
      end
      bif.start = (t == extra_t);
      bif.abort = (t == ab_t);
      if (t == 1) begin
        bif.gate_sel = 3'($urandom);
        bif.loops    = CW'($urandom);
      end
    end
    bif.start = 1'b0;
    bif.abort = 1'b0;
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_timeout: %0d expected events never seen", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bif.start = 1'b0; bif.abort = 1'b0; bif.gate_sel = 3'd0; bif.loops = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run(2, 1, 0, 2, 0, 3);      // healthy NAND, plus an ignored start while busy
    run(2, 1, 0, 0, 0, 0);      // AND model checked as NAND
    run(2, 3, 2, 0, 0, 0);      // Y stuck at 1, three loops
    run(4, 255, 3, 4, 0, 0);    // inverted XOR: error count saturates
    run(4, 0, 0, 4, 0, 0);      // loops=0 acts as one loop
    run(3, 2, 1, 0, 4, 2);      // abort on cycle 4 with a restart attempt before it

    // start together with abort in IDLE is ignored
    bif.start = 1'b1; bif.abort = 1'b1;
    @(negedge clk);
    bif.start = 1'b0; bif.abort = 1'b0;
    chk("start_abort_idle_busy", int'(bif.busy), 0);
    @(negedge clk);

    // Reset in the middle of a failing run
    mode = 1; fn = 0;
    bif.gate_sel = 3'd2; bif.loops = 8'd2; bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_err", int'(bif.err_count), 1);
    chk("pre_reset_busy", int'(bif.busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrun_reset");
    rst_n = 1'b1;
    @(negedge clk);
    run(5, 1, 0, 5, 0, 0);

    for (int r = 0; r < 30; r++) begin
      int sel, lp, md, f, leff, ab, ex;
      sel  = $urandom_range(7, 0);
      lp   = $urandom_range(4, 0);
      md   = $urandom_range(3, 0);
      f    = $urandom_range(7, 0);
      leff = (lp == 0) ? 1 : lp;
      ab   = ($urandom_range(3, 0) == 0) ? $urandom_range(4 * leff * S, 1) : 0;
      ex   = ($urandom_range(1, 0) == 1) ? $urandom_range((ab == 0) ? 4 * leff * S + 1 : ab, 1) : 0;
      run(sel, lp, md, f, ab, ex);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
